// File: rtl/ex_pkg.sv
// Shared decode/execute definitions: bus widths, aluop and alusel codes,
// and the state encoding of the iterative multiplier.
package ex_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 8;
    localparam int ALUSEL_W   = 3;

    typedef logic [ALUOP_W-1:0]    AluOpBus;
    typedef logic [ALUSEL_W-1:0]   AluSelBus;
    typedef logic [REG_W-1:0]      RegBus;
    typedef logic [REG_ADDR_W-1:0] RegAddrBus;

    localparam AluOpBus EXE_NOP_OP   = 8'b0000_0000;
    localparam AluOpBus EXE_AND_OP   = 8'b0010_0100;
    localparam AluOpBus EXE_OR_OP    = 8'b0010_0101;
    localparam AluOpBus EXE_XOR_OP   = 8'b0010_0110;
    localparam AluOpBus EXE_NOR_OP   = 8'b0010_0111;
    localparam AluOpBus EXE_SLL_OP   = 8'b0111_1100;
    localparam AluOpBus EXE_SRL_OP   = 8'b0000_0010;
    localparam AluOpBus EXE_SRA_OP   = 8'b0000_0011;
    localparam AluOpBus EXE_MFHI_OP  = 8'b0001_0000;
    localparam AluOpBus EXE_MTHI_OP  = 8'b0001_0001;
    localparam AluOpBus EXE_MFLO_OP  = 8'b0001_0010;
    localparam AluOpBus EXE_MTLO_OP  = 8'b0001_0011;
    localparam AluOpBus EXE_MULT_OP  = 8'b0001_1000;
    localparam AluOpBus EXE_MULTU_OP = 8'b0001_1001;

    localparam AluSelBus EXE_RES_NOP   = 3'b000;
    localparam AluSelBus EXE_RES_LOGIC = 3'b001;
    localparam AluSelBus EXE_RES_SHIFT = 3'b010;
    localparam AluSelBus EXE_RES_MOVE  = 3'b011;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle over DW steps,
// operands reduced to magnitudes and the sign restored on the final product.
module mul_iter
    import ex_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_signed,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [2*DW-1:0] result
);

    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

    mul_state_t      state;
    mul_state_t      state_nx;
    logic [CW-1:0]   cnt;
    logic [2*DW-1:0] acc;
    logic [2*DW-1:0] mcand;
    logic [DW-1:0]   mplier;
    logic            neg;
    logic [DW-1:0]   a_mag;
    logic [DW-1:0]   b_mag;

    // Magnitude of the most negative operand is 2^(DW-1), which still fits unsigned.
    assign a_mag = (is_signed && a[DW-1]) ? (~a + 1'b1) : a;
    assign b_mag = (is_signed && b[DW-1]) ? (~b + 1'b1) : b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MUL_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                MUL_IDLE: begin
                    if (start && !flush) begin
                        cnt    <= '0;
                        acc    <= '0;
                        mcand  <= {{DW{1'b0}}, a_mag};
                        mplier <= b_mag;
                        neg    <= is_signed & (a[DW-1] ^ b[DW-1]);
                    end
                end
                MUL_BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // A flush in any state falls back to IDLE without producing a result.
    always_comb begin
        state_nx = state;
        case (state)
            MUL_IDLE: if (start && !flush) state_nx = MUL_BUSY;
            MUL_BUSY: begin
                if (flush)                  state_nx = MUL_IDLE;
                else if (cnt == LAST_STEP)  state_nx = MUL_DONE;
            end
            MUL_DONE: state_nx = MUL_IDLE;
            default:  state_nx = MUL_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        result = neg ? (~acc + 1'b1) : acc;
        case (state)
            MUL_IDLE: busy = start && !flush;
            MUL_BUSY: busy = !flush;
            MUL_DONE: done = !flush;
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/ex.sv
// Execute stage: single-cycle logic/shift/move ALU, architectural HI/LO,
// and an iterative multiplier that stalls the front of the pipeline.
module ex
    import ex_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    aluop_i,
    input  logic [2:0]    alusel_i,
    input  logic [DW-1:0] reg1_i,
    input  logic [DW-1:0] reg2_i,
    input  logic [AW-1:0] wd_i,
    input  logic          wreg_i,
    input  logic          flush_i,
    output logic [AW-1:0] wd_o,
    output logic          wreg_o,
    output logic [DW-1:0] wdata_o,
    output logic          stallreq_o,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);

    logic [DW-1:0]   hi;
    logic [DW-1:0]   lo;
    logic            is_mul;
    logic            is_mt;
    logic            mul_busy;
    logic            mul_done;
    logic [2*DW-1:0] mul_result;
    logic [DW-1:0]   alu_res;

    assign is_mul = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
    assign is_mt  = (aluop_i == EXE_MTHI_OP) || (aluop_i == EXE_MTLO_OP);

    mul_iter #(.DW(DW)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (is_mul),
        .is_signed (aluop_i == EXE_MULT_OP),
        .a         (reg1_i),
        .b         (reg2_i),
        .flush     (flush_i),
        .busy      (mul_busy),
        .done      (mul_done),
        .result    (mul_result)
    );

    // A completing multiply wins over an MT* write should both ever coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (mul_done) begin
            hi <= mul_result[2*DW-1:DW];
            lo <= mul_result[DW-1:0];
        end else if (!flush_i && aluop_i == EXE_MTHI_OP) begin
            hi <= reg1_i;
        end else if (!flush_i && aluop_i == EXE_MTLO_OP) begin
            lo <= reg1_i;
        end
    end

    always_comb begin
        alu_res = '0;
        case (alusel_i)
            EXE_RES_LOGIC: begin
                case (aluop_i)
                    EXE_AND_OP: alu_res = reg1_i & reg2_i;
                    EXE_OR_OP:  alu_res = reg1_i | reg2_i;
                    EXE_XOR_OP: alu_res = reg1_i ^ reg2_i;
                    EXE_NOR_OP: alu_res = ~(reg1_i | reg2_i);
                    default:    alu_res = '0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (aluop_i)
                    EXE_SLL_OP: alu_res = reg2_i << reg1_i[4:0];
                    EXE_SRL_OP: alu_res = reg2_i >> reg1_i[4:0];
                    EXE_SRA_OP: alu_res = $signed(reg2_i) >>> reg1_i[4:0];
                    default:    alu_res = '0;
                endcase
            end
            EXE_RES_MOVE: begin
                case (aluop_i)
                    EXE_MFHI_OP: alu_res = hi;
                    EXE_MFLO_OP: alu_res = lo;
                    default:     alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        stallreq_o = 1'b0;
        if (!rst) begin
            wd_o       = wd_i;
            wreg_o     = wreg_i && !is_mul && !is_mt;
            wdata_o    = alu_res;
            stallreq_o = mul_busy;
        end
    end

    assign hi_o = hi;
    assign lo_o = lo;

endmodule

// File: tb/tb_ex.sv
// Directed bench for the execute stage: stimulus pushes expected outputs per
// cycle into a scoreboard queue that a negedge monitor drains and compares.
module tb_ex;
    import ex_pkg::*;

    typedef struct packed {
        logic [31:0] cyc;
        logic [5:0]  mask;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        stall;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    localparam logic [5:0] M_OUT = 6'b001111;
    localparam logic [5:0] M_HI  = 6'b010000;
    localparam logic [5:0] M_LO  = 6'b100000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic        flush;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    logic [31:0] cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        exp_q[$];
    string       name_q[$];

    ex #(.DW(32), .AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop),
        .alusel_i   (alusel),
        .reg1_i     (reg1),
        .reg2_i     (reg2),
        .wd_i       (wd),
        .wreg_i     (wreg),
        .flush_i    (flush),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stallreq_o (stallreq_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [4:0] d, input logic w,
                                 input logic fl, input logic rs);
        @(posedge clk);
        #1;
        aluop  = op;
        alusel = sel;
        reg1   = r1;
        reg2   = r2;
        wd     = d;
        wreg   = w;
        flush  = fl;
        rst    = rs;
    endtask

    task automatic expectOut(input string n, input logic [5:0] m,
                             input logic [4:0] d, input logic w,
                             input logic [31:0] data, input logic st,
                             input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.cyc   = cyc;
        e.mask  = m;
        e.wd    = d;
        e.wreg  = w;
        e.wdata = data;
        e.stall = st;
        e.hi    = h;
        e.lo    = l;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic checkOutput(input string n, input logic [31:0] act,
                               input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     n, act, req, cyc);
        end
    endtask

    // Monitor: compare every expectation registered for the current cycle.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (e.mask[0]) checkOutput({n, ".wd"},    {27'd0, wd_o},       {27'd0, e.wd});
                if (e.mask[1]) checkOutput({n, ".wreg"},  {31'd0, wreg_o},     {31'd0, e.wreg});
                if (e.mask[2]) checkOutput({n, ".wdata"}, wdata_o,             e.wdata);
                if (e.mask[3]) checkOutput({n, ".stall"}, {31'd0, stallreq_o}, {31'd0, e.stall});
                if (e.mask[4]) checkOutput({n, ".hi"},    hi_o,                e.hi);
                if (e.mask[5]) checkOutput({n, ".lo"},    lo_o,                e.lo);
            end
        end
    end

    // Runs one multiply for its full 34-cycle occupancy; flush_at/rst_at < 0 disables.
    task automatic runMul(input string n, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input int rst_at,
                          input logic chk_pre, input logic [31:0] pre_hi,
                          input logic [31:0] pre_lo);
        for (int i = 0; i < 34; i++) begin
            applyStimulus(op, EXE_RES_NOP, a, b, 5'd9, 1'b1,
                          (i == flush_at), (i == rst_at));
            if (i == rst_at) begin
                expectOut($sformatf("%s.rst%0d", n, i), M_OUT, 5'd0, 1'b0, 32'd0, 1'b0, 0, 0);
                return;
            end
            if (i == flush_at) begin
                expectOut($sformatf("%s.flush%0d", n, i), M_OUT, 5'd9, 1'b0, 32'd0, 1'b0, 0, 0);
                return;
            end
            expectOut($sformatf("%s.c%0d", n, i), M_OUT, 5'd9, 1'b0, 32'd0, (i < 33), 0, 0);
            if (i == 0 && chk_pre)
                expectOut($sformatf("%s.prev", n), M_HI | M_LO, 0, 0, 0, 0, pre_hi, pre_lo);
        end
    endtask

    initial begin
        rst = 1'b1; aluop = EXE_NOP_OP; alusel = EXE_RES_NOP;
        reg1 = '0; reg2 = '0; wd = '0; wreg = 1'b0; flush = 1'b0;

        applyStimulus(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000FFFF, 32'hFF00FF00, 5'd3, 1'b1, 1'b0, 1'b1);
        expectOut("reset", M_OUT | M_HI | M_LO, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);

        applyStimulus(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000FFFF, 32'hFF00FF00, 5'd3, 1'b1, 1'b0, 1'b0);
        expectOut("or", M_OUT, 5'd3, 1'b1, 32'hFF00FFFF, 1'b0, 0, 0);
        applyStimulus(EXE_AND_OP, EXE_RES_LOGIC, 32'h0000FFFF, 32'hFF00FF00, 5'd4, 1'b1, 1'b0, 1'b0);
        expectOut("and", M_OUT, 5'd4, 1'b1, 32'h0000FF00, 1'b0, 0, 0);
        applyStimulus(EXE_XOR_OP, EXE_RES_LOGIC, 32'h0000FFFF, 32'hFF00FF00, 5'd5, 1'b0, 1'b0, 1'b0);
        expectOut("xor", M_OUT, 5'd5, 1'b0, 32'hFF0000FF, 1'b0, 0, 0);
        applyStimulus(EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000FFFF, 32'hFF00FF00, 5'd6, 1'b1, 1'b0, 1'b0);
        expectOut("nor", M_OUT, 5'd6, 1'b1, 32'h00FF0000, 1'b0, 0, 0);

        applyStimulus(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h80000010, 5'd7, 1'b1, 1'b0, 1'b0);
        expectOut("sra", M_OUT, 5'd7, 1'b1, 32'hF8000001, 1'b0, 0, 0);
        applyStimulus(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h80000010, 5'd7, 1'b1, 1'b0, 1'b0);
        expectOut("srl", M_OUT, 5'd7, 1'b1, 32'h08000001, 1'b0, 0, 0);
        applyStimulus(EXE_SLL_OP, EXE_RES_SHIFT, 32'd0, 32'h80000010, 5'd7, 1'b1, 1'b0, 1'b0);
        expectOut("sll0", M_OUT, 5'd7, 1'b1, 32'h80000010, 1'b0, 0, 0);
        applyStimulus(EXE_SRA_OP, EXE_RES_SHIFT, 32'd0, 32'h80000010, 5'd7, 1'b1, 1'b0, 1'b0);
        expectOut("sra0", M_OUT, 5'd7, 1'b1, 32'h80000010, 1'b0, 0, 0);
        applyStimulus(EXE_SLL_OP, EXE_RES_SHIFT, 32'h00000024, 32'h80000010, 5'd8, 1'b1, 1'b0, 1'b0);
        expectOut("sll_amt5", M_OUT, 5'd8, 1'b1, 32'h00000100, 1'b0, 0, 0);
        applyStimulus(EXE_OR_OP, EXE_RES_NOP, 32'h0000FFFF, 32'hFF00FF00, 5'd2, 1'b1, 1'b0, 1'b0);
        expectOut("nop_sel", M_OUT, 5'd2, 1'b1, 32'd0, 1'b0, 0, 0);

        applyStimulus(EXE_MTLO_OP, EXE_RES_MOVE, 32'hDEADBEEF, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        expectOut("mtlo", M_OUT, 5'd0, 1'b0, 32'd0, 1'b0, 0, 0);
        applyStimulus(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd10, 1'b1, 1'b0, 1'b0);
        expectOut("mflo_mt", M_OUT | M_LO, 5'd10, 1'b1, 32'hDEADBEEF, 1'b0, 0, 32'hDEADBEEF);

        runMul("mult_neg", EXE_MULT_OP, 32'hFFFFFFFE, 32'd3, -1, -1, 1'b0, 0, 0);
        applyStimulus(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd11, 1'b1, 1'b0, 1'b0);
        expectOut("mfhi_neg", M_OUT, 5'd11, 1'b1, 32'hFFFFFFFF, 1'b0, 0, 0);
        applyStimulus(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd12, 1'b1, 1'b0, 1'b0);
        expectOut("mflo_neg", M_OUT, 5'd12, 1'b1, 32'hFFFFFFFA, 1'b0, 0, 0);

        runMul("multu_max", EXE_MULTU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, 1'b0, 0, 0);
        runMul("mult_min", EXE_MULT_OP, 32'h80000000, 32'h80000000, -1, -1,
               1'b1, 32'hFFFFFFFE, 32'h00000001);
        applyStimulus(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd13, 1'b1, 1'b0, 1'b0);
        expectOut("mfhi_min", M_OUT | M_LO, 5'd13, 1'b1, 32'h40000000, 1'b0, 0, 32'd0);

        applyStimulus(EXE_MTHI_OP, EXE_RES_MOVE, 32'h00000011, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        expectOut("mthi", M_OUT, 5'd0, 1'b0, 32'd0, 1'b0, 0, 0);
        runMul("mult_flush", EXE_MULT_OP, 32'd5, 32'd7, 10, -1, 1'b0, 0, 0);
        applyStimulus(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd14, 1'b1, 1'b0, 1'b0);
        expectOut("mfhi_flush", M_OUT | M_HI, 5'd14, 1'b1, 32'h00000011, 1'b0, 32'h00000011, 0);

        runMul("mult_rst", EXE_MULT_OP, 32'd5, 32'd7, -1, 5, 1'b0, 0, 0);
        applyStimulus(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd15, 1'b1, 1'b0, 1'b0);
        expectOut("after_rst", M_OUT | M_HI | M_LO, 5'd15, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);

        applyStimulus(EXE_MTHI_OP, EXE_RES_MOVE, 32'h00000055, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        expectOut("mthi_flushed", M_OUT, 5'd0, 1'b0, 32'd0, 1'b0, 0, 0);
        applyStimulus(EXE_MULT_OP, EXE_RES_NOP, 32'd5, 32'd7, 5'd1, 1'b1, 1'b1, 1'b0);
        expectOut("mult_flushed", M_OUT | M_HI, 5'd1, 1'b0, 32'd0, 1'b0, 32'd0, 0);
        applyStimulus(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        expectOut("idle_after_flush", M_OUT, 5'd1, 1'b0, 32'd0, 1'b0, 0, 0);

        applyStimulus(EXE_MFLO_OP, EXE_RES_MOVE, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 1'b1, 1'b0, 1'b1);
        expectOut("rst_mflo", M_OUT, 5'd0, 1'b0, 32'd0, 1'b0, 0, 0);

        applyStimulus(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex.md
Name: ex

Overview:
- Execute stage. Sits directly downstream of the id/ex pipeline register and consumes decode outputs: aluop, alusel, reg1, reg2, wd and wreg.
- Computes logic, shift and HI/LO-move results in a single cycle.
- Runs MULT/MULTU as an iterative 32-step shift-add multiplier and raises stallreq_o while the multiply is busy.
- Its wd_o/wreg_o/wdata_o feed the ex/mem register and the decode-stage bypass path (ex_wd/ex_wreg/ex_wdata).

Parameters:
- DW, 32, datapath width; must equal RegBus width.
- AW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset.
- aluop_i  in  8  operation code (shared aluop constants).
- alusel_i  in  3  result-class select.
- reg1_i  in  DW  operand 1 (shift amount in [4:0] for shifts).
- reg2_i  in  DW  operand 2 (value to shift).
- wd_i  in  AW  destination register.
- wreg_i  in  1  write enable from decode.
- flush_i  in  1  annul current EX op (exception/branch squash).
- wd_o  out  AW  destination passed through.
- wreg_o  out  1  write enable.
- wdata_o  out  DW  result.
- stallreq_o  out  1  requests hold of pc/if_id/id_ex.
- hi_o  out  DW  architectural HI.
- lo_o  out  DW  architectural LO.

Behaviour:
- Reset is rst: synchronous, active-high. On reset: state=IDLE, HI=LO=0, iteration counter=0.
- While rst=1, all combinational outputs are forced to 0: wd_o, wreg_o, wdata_o, stallreq_o.
- Logic ops (alusel=RES_LOGIC), combinational, 0-cycle:
  - AND_OP, OR_OP, XOR_OP: reg1 op reg2.
  - NOR_OP: ~(reg1|reg2).
- Shift ops (alusel=RES_SHIFT):
  - SLL_OP: reg2<<reg1[4:0].
  - SRL_OP: logical right shift.
  - SRA_OP: arithmetic right shift (sign fill). Shift by 0 returns reg2 unchanged.
- Move ops (alusel=RES_MOVE):
  - MFHI_OP/MFLO_OP: wdata_o = HI/LO.
  - MTHI_OP/MTLO_OP: write HI/LO with reg1 at the clock edge. wreg_o=0 for MT*.
- Result-class rules:
  - alusel=RES_NOP or unknown: wdata_o=0.
  - wd_o=wd_i always.
  - wreg_o=wreg_i, except MULT/MULTU/MT* force 0.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE: when aluop∈{MULT_OP,MULTU_OP} and flush_i=0, latch operands, go to BUSY, and assert stallreq_o combinationally this cycle. Sign handling:
    - MULT: latch |reg1|,|reg2| and neg = reg1[31]^reg2[31].
    - MULTU: latch raw operands, neg=0.
  - BUSY: one shift-add step per cycle over a 64-bit accumulator; counter 0..31. After step 31 go to DONE. stallreq_o=1 throughout BUSY.
  - DONE: stallreq_o=0. Result = neg ? -acc : acc. {HI,LO} is written at the end of this cycle; go to IDLE.
- Multiply timing:
  - Total EX occupancy is 34 cycles (1 IDLE + 32 BUSY + 1 DONE), 33 of them stalled.
  - An instruction in the next cycle reading HI/LO sees the new value; no HI/LO bypass is needed.
- Back-to-back MULT: the second MULT arrives in the cycle after DONE, in IDLE, and starts normally.
- flush_i=1 in BUSY or DONE:
  - Abort to IDLE with no HI/LO write; stallreq_o drops that same cycle.
  - flush_i in IDLE blocks MULT start and MT* writes.
- rst mid-multiply: IDLE, HI/LO cleared, no write.
- Simultaneous HI/LO write sources cannot occur, because the pipeline is stalled during a multiply. If they ever did, DONE takes priority.
- 32×32→64 arithmetic: 2's-complement negation on 64 bits. The most-negative operand (0x80000000) has magnitude 2^31, which fits unsigned.

Decomposition:
- Shared defines package:
  - Existing AluOpBus/AluSelBus/RegBus/RegAddrBus, EXE_*_OP and EXE_RES_* constants.
  - Add MFHI_OP, MFLO_OP, MTHI_OP, MTLO_OP, MULT_OP, MULTU_OP, EXE_RES_MOVE.
  - Add mul FSM state encoding.
- One sub-module, mul_iter: FSM, counter, accumulator and sign fix. Interface: start, signed, a, b, flush, busy, done, result[63:0].
- ex itself holds the combinational ALU mux and HI/LO.

Test Plan:
- OR_OP reg1=0x0000FFFF, reg2=0xFF00FF00, wd=3, wreg=1 -> same cycle wdata_o=0xFF00FFFF, wd_o=3, wreg_o=1, stallreq_o=0.
- SRA_OP reg1=4, reg2=0x80000010 -> wdata_o=0xF8000001; SRL_OP same -> 0x08000001; SLL_OP reg1=0 -> 0x80000010.
- MULT reg1=0xFFFFFFFE (-2), reg2=3 -> stallreq_o high 33 cycles, low in cycle 34. Next cycle MFHI gives 0xFFFFFFFF, MFLO gives 0xFFFFFFFA. wreg_o=0 during MULT.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Back-to-back MULT 0x80000000×0x80000000 -> HI=0x40000000, LO=0.
- flush_i pulsed at BUSY cycle 10 with HI=0x11 pre-set via MTHI -> stallreq_o drops that cycle, HI still 0x11. rst at BUSY cycle 5 -> HI=LO=0, stallreq_o=0.
- MTLO reg1=0xDEADBEEF then MFLO next cycle -> wdata_o=0xDEADBEEF. With rst=1 any op -> all outputs 0.
